pix_clk_ctrl: RTL

//  Sequences runtime changes of the pixel-rate numerator (freq) that drives the fractional

---
 rtl/pix_clk_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/pix_clk_ctrl.sv
// pix_clk_ctrl: sequences runtime changes of the pixel-rate numerator (freq)
// fed to the fractional clock-enable generator. A new rate is accepted by
// valid/ready handshake and range-checked. The change then waits for a frame
// boundary (or a timeout) and blanks the video path while the pipeline drains.
// It applies the new freq and holds blank until the enable pulses have settled.
module pix_clk_ctrl #(
    parameter int INPUT_FREQ     = 125,
    parameter int INPUT_WIDTH    = 8,
    parameter int DEFAULT_FREQ   = 25,
    parameter int DRAIN_CYCLES   = 4,
    parameter int SETTLE_PULSES  = 2,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    input  logic [INPUT_WIDTH-1:0] req_freq,
    output logic                   req_ready,
    input  logic                   frame_end,
    input  logic                   en,
    output logic [INPUT_WIDTH-1:0] freq_out,
    output logic                   blank,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic                   timeout
);

    localparam int TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int DRAIN_W  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int SETTLE_W = (SETTLE_PULSES > 1) ? $clog2(SETTLE_PULSES) : 1;

    localparam logic [INPUT_WIDTH-1:0] MAX_FREQ    = INPUT_WIDTH'(INPUT_FREQ);
    localparam logic [INPUT_WIDTH-1:0] DEF_FREQ    = INPUT_WIDTH'(DEFAULT_FREQ);
    localparam logic [TMO_W-1:0]       TMO_LAST    = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DRAIN_W-1:0]     DRAIN_LAST  = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [SETTLE_W-1:0]    SETTLE_LAST = SETTLE_W'(SETTLE_PULSES - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FRAME,
        DRAIN,
        APPLY,
        SETTLE
    } state_t;

    state_t                 state_q, state_d;
    logic [INPUT_WIDTH-1:0] freq_out_q, freq_out_d;
    logic [INPUT_WIDTH-1:0] pending_q, pending_d;
    logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic [DRAIN_W-1:0]     drain_cnt_q, drain_cnt_d;
    logic [SETTLE_W-1:0]    settle_cnt_q, settle_cnt_d;
    logic                   reset_settle_q, reset_settle_d;
    logic                   blank_q, blank_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   timeout_q, timeout_d;

    // Next-state and registered-output logic for the rate-change sequencer;
    // the settle after reset is flagged so it completes without a done pulse.
    always_comb begin
        state_d        = state_q;
        freq_out_d     = freq_out_q;
        pending_d      = pending_q;
        tmo_cnt_d      = tmo_cnt_q;
        drain_cnt_d    = drain_cnt_q;
        settle_cnt_d   = settle_cnt_q;
        reset_settle_d = reset_settle_q;
        done_d         = 1'b0;
        err_d          = 1'b0;
        timeout_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_freq == '0 || req_freq > MAX_FREQ) begin
                        err_d = 1'b1;
                    end else if (req_freq == freq_out_q) begin
                        done_d = 1'b1;
                    end else begin
                        pending_d = req_freq;
                        tmo_cnt_d = '0;
                        state_d   = WAIT_FRAME;
                    end
                end
            end
            WAIT_FRAME: begin
                if (frame_end) begin
                    drain_cnt_d = '0;
                    state_d     = DRAIN;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    timeout_d   = 1'b1;
                    drain_cnt_d = '0;
                    state_d     = DRAIN;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = APPLY;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
                end
            end
            APPLY: begin
                freq_out_d     = pending_q;
                settle_cnt_d   = '0;
                reset_settle_d = 1'b0;
                state_d        = SETTLE;
            end
            SETTLE: begin
                if (en) begin
                    if (settle_cnt_q == SETTLE_LAST) begin
                        done_d         = ~reset_settle_q;
                        reset_settle_d = 1'b0;
                        state_d        = IDLE;
                    end else begin
                        settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        blank_d = (state_d == DRAIN) || (state_d == APPLY) || (state_d == SETTLE);
    end

    // State and output registers; reset lands in SETTLE with blank held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= SETTLE;
            freq_out_q     <= DEF_FREQ;
            pending_q      <= DEF_FREQ;
            tmo_cnt_q      <= '0;
            drain_cnt_q    <= '0;
            settle_cnt_q   <= '0;
            reset_settle_q <= 1'b1;
            blank_q        <= 1'b1;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            freq_out_q     <= freq_out_d;
            pending_q      <= pending_d;
            tmo_cnt_q      <= tmo_cnt_d;
            drain_cnt_q    <= drain_cnt_d;
            settle_cnt_q   <= settle_cnt_d;
            reset_settle_q <= reset_settle_d;
            blank_q        <= blank_d;
            done_q         <= done_d;
            err_q          <= err_d;
            timeout_q      <= timeout_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign freq_out  = freq_out_q;
    assign blank     = blank_q;
    assign done      = done_q;
    assign err       = err_q;
    assign timeout   = timeout_q;

endmodule
